// File: rtl/pulse_run_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pulse_run_sequencer_if
// Purpose  : Command handshake bundle for pulse_run_sequencer. Carries one
//            burst command (run length, gap length, repeat count) from the
//            control logic to the sequencer over a valid/ready handshake.
// Signals  : cmd_valid   - command present (master -> slave)
//            cmd_ready   - sequencer can accept (slave -> master)
//            cmd_run_len - counted cycles per burst
//            cmd_gap_len - idle cycles between bursts
//            cmd_repeat  - number of bursts minus 1
// Modports : master (control logic), slave (sequencer)
// Revision : 1.0 - initial release
// ============================================================================
interface pulse_run_sequencer_if #(
  parameter int LEN_W = 8,
  parameter int REP_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_run_len;
  logic [LEN_W-1:0] cmd_gap_len;
  logic [REP_W-1:0] cmd_repeat;

  modport master (
    output cmd_valid, cmd_run_len, cmd_gap_len, cmd_repeat,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_run_len, cmd_gap_len, cmd_repeat,
    output cmd_ready
  );
endinterface
`default_nettype wire

// File: rtl/pulse_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pulse_run_sequencer
// Purpose  : Initiator side of the start/stop pulse-counter protocol. Accepts
//            a burst command and drives one-cycle start/stop pulses to a
//            downstream pulse counter, repeating the burst a programmed number
//            of times. exp_count tracks the counter value cycle by cycle.
// Ports    : clk       - clock, rising edge
//            reset     - synchronous, active-high reset
//            cmd       - command handshake (pulse_run_sequencer_if.slave)
//            abort     - early termination (only with PULSE_SEQ_ABORT_EN)
//            start     - registered one-cycle start pulse
//            stop      - registered one-cycle stop pulse
//            busy      - high whenever the FSM is not idle
//            done      - one-cycle pulse at command completion
//            exp_count - modelled counter value
// Options  : define PULSE_SEQ_ABORT_EN to add the abort input.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_run_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX        = 20,
  parameter int LEN_W      = 8,
  parameter int REP_W      = 4
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  pulse_run_sequencer_if.slave       cmd,
`ifdef PULSE_SEQ_ABORT_EN
  input  wire logic                  abort,
`endif
  output logic                       start,
  output logic                       stop,
  output logic                       busy,
  output logic                       done,
  output logic [DATA_WIDTH-1:0]      exp_count
);

  localparam logic [DATA_WIDTH-1:0] MAX_V = DATA_WIDTH'(MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_STOP  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] run_len;
  logic [LEN_W-1:0] gap_len;
  logic [REP_W-1:0] bursts_left;
  logic [LEN_W-1:0] run_cnt;
  logic [LEN_W-1:0] gap_cnt;
  logic             abort_hit;

`ifdef PULSE_SEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cmd.cmd_ready <= 1'b1;
      start         <= 1'b0;
      stop          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      exp_count     <= '0;
      run_len       <= '0;
      gap_len       <= '0;
      bursts_left   <= '0;
      run_cnt       <= '0;
      gap_cnt       <= '0;
    end else begin
      start <= 1'b0;
      stop  <= 1'b0;
      done  <= 1'b0;

      // The counter sees start high during S_START and counts through S_RUN.
      if (state == S_START || state == S_RUN) begin
        exp_count <= (exp_count == MAX_V) ? '0 : exp_count + DATA_WIDTH'(1);
      end

      case (state)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            run_len       <= cmd.cmd_run_len;
            gap_len       <= cmd.cmd_gap_len;
            bursts_left   <= cmd.cmd_repeat;
            cmd.cmd_ready <= 1'b0;
            busy          <= 1'b1;
            if (cmd.cmd_run_len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_START;
              start <= 1'b1;
            end
          end
        end

        S_START: begin
          // Abort forces the coming stop to be the last one.
          if (abort_hit) bursts_left <= '0;
          if (abort_hit || run_len == LEN_W'(1)) begin
            state <= S_STOP;
            stop  <= 1'b1;
          end else begin
            // Start cycle already counted once; the stop cycle does not count.
            run_cnt <= run_len - LEN_W'(2);
            state   <= S_RUN;
          end
        end

        S_RUN: begin
          if (abort_hit) bursts_left <= '0;
          if (abort_hit || run_cnt == '0) begin
            state <= S_STOP;
            stop  <= 1'b1;
          end else begin
            run_cnt <= run_cnt - LEN_W'(1);
          end
        end

        S_STOP: begin
          if (abort_hit || bursts_left == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            bursts_left <= bursts_left - REP_W'(1);
            if (gap_len != '0) begin
              gap_cnt <= gap_len;
              state   <= S_GAP;
            end else begin
              state <= S_START;
              start <= 1'b1;
            end
          end
        end

        S_GAP: begin
          if (abort_hit) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (gap_cnt == LEN_W'(1)) begin
            state <= S_START;
            start <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - LEN_W'(1);
          end
        end

        S_DONE: begin
          state         <= S_IDLE;
          busy          <= 1'b0;
          cmd.cmd_ready <= 1'b1;
        end

        default: begin
          state         <= S_IDLE;
          busy          <= 1'b0;
          cmd.cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
